decode_ctrl_stage: RTL and testbench

Registered, handshaked decode stage for the accumulator-style core; the successor to the combinational main decoder. Decodes a parametrised-width opcode into the control bundle and holds it in a one-entry output register. Detects load-use hazards against the instruction it is holding and inserts one bubble. Supports flush from branch resolution and halts on illegal opcodes. Sits between fetch (upstream valid/ready) and execute (downstream valid/ready).

---
 rtl/ctrl_pkg.sv | 48 ++++
 rtl/op_decode.sv | 77 +++++++
 rtl/decode_ctrl_stage.sv | 158 +++++++++++++++
 tb/tb_decode_ctrl_stage.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// -----------------------------------------------------------------------------
// ctrl_pkg
// Shared definitions for the decode stage of the accumulator-style core:
//   - 3-bit opcode class codes (CLS_*) and sub-operation codes (SUB_*)
//   - ctrl_t : packed 9-bit control bundle
//              {reg_write, alu_src, branch, mem_write, mem_to_reg,
//               jump[1:0], alu_op[1:0]}
//   - state_t: stage FSM states RUN / STALL / HALT
//   - is_load: helper that identifies a bundle which writes back from memory
// -----------------------------------------------------------------------------
package ctrl_pkg;

    localparam logic [2:0] CLS_SGR = 3'b000;
    localparam logic [2:0] CLS_SSR = 3'b001;
    localparam logic [2:0] CLS_SI0 = 3'b010;
    localparam logic [2:0] CLS_SI1 = 3'b011;
    localparam logic [2:0] CLS_DR  = 3'b100;
    localparam logic [2:0] CLS_GR  = 3'b101;
    localparam logic [2:0] CLS_JR  = 3'b110;
    localparam logic [2:0] CLS_J   = 3'b111;

    localparam logic [2:0] SUB_LWR = 3'b000;
    localparam logic [2:0] SUB_STR = 3'b001;
    localparam logic [2:0] SUB_NOP = 3'b010;
    localparam logic [2:0] SUB_BRC = 3'b101;

    typedef struct packed {
        logic       reg_write;
        logic       alu_src;
        logic       branch;
        logic       mem_write;
        logic       mem_to_reg;
        logic [1:0] jump;
        logic [1:0] alu_op;
    } ctrl_t;

    typedef enum logic [1:0] {
        RUN   = 2'b00,
        STALL = 2'b01,
        HALT  = 2'b10
    } state_t;

    // A bundle that loads from memory is the producer side of a load-use hazard.
    function automatic logic is_load(input ctrl_t c);
        return c.mem_to_reg;
    endfunction

endpackage

// File: rtl/op_decode.sv
// -----------------------------------------------------------------------------
// op_decode
// Purely combinational opcode table. The class is the top three opcode bits,
// the sub-operation the bottom three; any bits in between are ignored.
// Parameter: OP_W (>= 6)
// Ports:
//   op      in  OP_W  opcode
//   ctrl    out 9     decoded control bundle (all zero for illegal opcodes)
//   illegal out 1     opcode has no defined meaning
// -----------------------------------------------------------------------------
module op_decode
    import ctrl_pkg::*;
#(
    parameter int OP_W = 6
) (
    input  logic [OP_W-1:0] op,
    output ctrl_t           ctrl,
    output logic            illegal
);

    logic [2:0] cls_s;
    logic [2:0] sub_s;
    // Middle opcode bits carry no meaning; folded here so they count as consumed.
    logic       unused_op_s;

    assign cls_s       = op[OP_W-1 -: 3];
    assign sub_s       = op[2:0];
    assign unused_op_s = ^op;

    // Class/sub-operation lookup; everything not set explicitly stays 0.
    always_comb begin
        ctrl    = 9'b0;
        illegal = 1'b0;
        case (cls_s)
            CLS_SGR: ctrl.reg_write = 1'b1;
            CLS_SSR: begin
                case (sub_s)
                    SUB_LWR: begin
                        ctrl.reg_write  = 1'b1;
                        ctrl.mem_to_reg = 1'b1;
                    end
                    SUB_STR: ctrl.mem_write = 1'b1;
                    SUB_NOP: ctrl = 9'b0;
                    default: illegal = 1'b1;
                endcase
            end
            CLS_SI0, CLS_SI1: begin
                if (sub_s == SUB_BRC) begin
                    ctrl.branch = 1'b1;
                    ctrl.alu_op = 2'b11;
                end else begin
                    ctrl.reg_write = 1'b1;
                    ctrl.alu_src   = 1'b1;
                    ctrl.alu_op    = 2'b01;
                end
            end
            CLS_DR: begin
                ctrl.reg_write = 1'b1;
                ctrl.alu_op    = 2'b10;
            end
            CLS_GR: begin
                ctrl.reg_write = 1'b1;
                ctrl.alu_op    = 2'b01;
            end
            CLS_JR: begin
                ctrl.jump   = 2'b11;
                ctrl.alu_op = 2'b11;
            end
            CLS_J: begin
                ctrl.jump   = 2'b01;
                ctrl.alu_op = 2'b11;
            end
            default: ctrl = 9'b0;
        endcase
    end

endmodule

// File: rtl/decode_ctrl_stage.sv
// -----------------------------------------------------------------------------
// decode_ctrl_stage
// Registered, valid/ready handshaked decode stage. Holds one decoded control
// bundle, inserts a one-cycle bubble on a load-use hazard against the held
// instruction, drops everything on flush and halts on an illegal opcode.
// Parameters: OP_W (opcode width, >= 6), RA_W (register address width)
// Ports:
//   clk, reset            clock (rising edge), asynchronous active-high reset
//   in_valid/in_ready     fetch handshake; in_op, in_rs, in_rd instruction
//   flush                 drop held entry and incoming instruction this cycle
//   out_valid/out_ready   execute handshake; out_ctrl, out_rd held bundle
//   illegal               sticky illegal-opcode flag
//   halted                stage is in HALT
// Optional build macro DECODE_PERF_CNT_EN adds:
//   perf_issued[31:0]     accepted instructions (wraps)
//   perf_stalls[31:0]     cycles spent in STALL (wraps)
// -----------------------------------------------------------------------------
module decode_ctrl_stage
    import ctrl_pkg::*;
#(
    parameter int OP_W = 6,
    parameter int RA_W = 3
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [OP_W-1:0] in_op,
    input  logic [RA_W-1:0] in_rs,
    input  logic [RA_W-1:0] in_rd,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [8:0]      out_ctrl,
    output logic [RA_W-1:0] out_rd,
    output logic            illegal,
    output logic            halted
`ifdef DECODE_PERF_CNT_EN
    ,
    output logic [31:0]     perf_issued,
    output logic [31:0]     perf_stalls
`endif
);

    ctrl_t           dec_ctrl_s;
    logic            dec_illegal_s;

    state_t          state_r;
    logic            out_valid_r;
    ctrl_t           out_ctrl_r;
    logic [RA_W-1:0] out_rd_r;
    logic            illegal_r;
    logic            halted_r;

    logic            hazard_s;
    logic            in_ready_s;
    logic            accept_s;

    op_decode #(
        .OP_W(OP_W)
    ) u_op_decode (
        .op     (in_op),
        .ctrl   (dec_ctrl_s),
        .illegal(dec_illegal_s)
    );

    // Handshake qualification: hazard against the held load, readiness, accept.
    always_comb begin
        hazard_s   = out_valid_r && is_load(out_ctrl_r) && in_valid && (in_rs == out_rd_r);
        in_ready_s = (state_r == RUN) && !hazard_s && (!out_valid_r || out_ready) && !flush;
        accept_s   = in_valid && in_ready_s;
    end

    // Stage FSM together with the one-entry output register and status flags.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r     <= RUN;
            out_valid_r <= 1'b0;
            out_ctrl_r  <= 9'b0;
            out_rd_r    <= {RA_W{1'b0}};
            illegal_r   <= 1'b0;
            halted_r    <= 1'b0;
        end else begin
            case (state_r)
                RUN: begin
                    if (flush) begin
                        out_valid_r <= 1'b0;
                    end else if (accept_s) begin
                        if (dec_illegal_s) begin
                            // Nothing is issued for an illegal opcode; the stage parks.
                            out_valid_r <= 1'b0;
                            illegal_r   <= 1'b1;
                            halted_r    <= 1'b1;
                            state_r     <= HALT;
                        end else begin
                            // Replaces the entry even if it drains on this same edge.
                            out_valid_r <= 1'b1;
                            out_ctrl_r  <= dec_ctrl_s;
                            out_rd_r    <= in_rd;
                        end
                    end else begin
                        if (out_ready) begin
                            out_valid_r <= 1'b0;
                        end
                        if (hazard_s) begin
                            state_r <= STALL;
                        end
                    end
                end
                STALL: begin
                    // Leave once the load has gone downstream, leaving a bubble behind.
                    if (flush || out_ready) begin
                        out_valid_r <= 1'b0;
                        state_r     <= RUN;
                    end
                end
                HALT: begin
                    out_valid_r <= 1'b0;
                end
                default: begin
                    out_valid_r <= 1'b0;
                    state_r     <= RUN;
                end
            endcase
        end
    end

`ifdef DECODE_PERF_CNT_EN
    logic [31:0] perf_issued_r;
    logic [31:0] perf_stalls_r;

    // Free-running event counters; they wrap naturally at 2^32.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_issued_r <= 32'd0;
            perf_stalls_r <= 32'd0;
        end else begin
            if (accept_s) begin
                perf_issued_r <= perf_issued_r + 32'd1;
            end
            if (state_r == STALL) begin
                perf_stalls_r <= perf_stalls_r + 32'd1;
            end
        end
    end

    assign perf_issued = perf_issued_r;
    assign perf_stalls = perf_stalls_r;
`endif

    assign in_ready  = in_ready_s;
    assign out_valid = out_valid_r;
    assign out_ctrl  = out_ctrl_r;
    assign out_rd    = out_rd_r;
    assign illegal   = illegal_r;
    assign halted    = halted_r;

endmodule

// File: tb/tb_decode_ctrl_stage.sv
// -----------------------------------------------------------------------------
// tb_decode_ctrl_stage
// Self-checking bench for decode_ctrl_stage: directed scenario tasks plus a
// randomized run compared against a behavioural model of the stage.
// A second instance with OP_W=8 covers the wide-opcode case.
// -----------------------------------------------------------------------------
module tb_decode_ctrl_stage;

    logic       clk = 1'b0;
    logic       reset = 1'b1;

    logic       in_valid, flush, out_ready;
    logic [5:0] in_op;
    logic [2:0] in_rs, in_rd;
    logic       in_ready, out_valid, illegal, halted;
    logic [8:0] out_ctrl;
    logic [2:0] out_rd;

    logic       w_in_valid, w_flush, w_out_ready;
    logic [7:0] w_in_op;
    logic [2:0] w_in_rs, w_in_rd;
    logic       w_in_ready, w_out_valid, w_illegal, w_halted;
    logic [8:0] w_out_ctrl;
    logic [2:0] w_out_rd;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    decode_ctrl_stage #(.OP_W(6), .RA_W(3)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_rs(in_rs), .in_rd(in_rd), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl),
        .out_rd(out_rd), .illegal(illegal), .halted(halted)
    );

    decode_ctrl_stage #(.OP_W(8), .RA_W(3)) dut8 (
        .clk(clk), .reset(reset), .in_valid(w_in_valid), .in_ready(w_in_ready),
        .in_op(w_in_op), .in_rs(w_in_rs), .in_rd(w_in_rd), .flush(w_flush),
        .out_valid(w_out_valid), .out_ready(w_out_ready), .out_ctrl(w_out_ctrl),
        .out_rd(w_out_rd), .illegal(w_illegal), .halted(w_halted)
    );

    // Reference decode table: returns {illegal, RegWrite, ALUSrc, Branch,
    // MemWrite, MemToReg, Jump[1:0], ALUOp[1:0]}.
    function automatic logic [9:0] ref_decode(input logic [2:0] cls, input logic [2:0] sub);
        logic rw, src, br, mw, mtr, ill;
        logic [1:0] jmp, alu;
        rw = 1'b0; src = 1'b0; br = 1'b0; mw = 1'b0; mtr = 1'b0; ill = 1'b0;
        jmp = 2'b00; alu = 2'b00;
        case (cls)
            3'd0: rw = 1'b1;
            3'd1: begin
                if (sub == 3'd0) begin rw = 1'b1; mtr = 1'b1; end
                else if (sub == 3'd1) mw = 1'b1;
                else if (sub != 3'd2) ill = 1'b1;
            end
            3'd2, 3'd3: begin
                if (sub == 3'd5) begin br = 1'b1; alu = 2'b11; end
                else begin rw = 1'b1; src = 1'b1; alu = 2'b01; end
            end
            3'd4: begin rw = 1'b1; alu = 2'b10; end
            3'd5: begin rw = 1'b1; alu = 2'b01; end
            3'd6: begin jmp = 2'b11; alu = 2'b11; end
            default: begin jmp = 2'b01; alu = 2'b11; end
        endcase
        return {ill, rw, src, br, mw, mtr, jmp, alu};
    endfunction

    // Behavioural model of the stage: what is held, whether a bubble is pending,
    // whether the stage has halted.
    logic       m_valid, m_stall, m_halt, m_ill;
    logic [8:0] m_ctrl;
    logic [2:0] m_rd;
    logic [9:0] in_dec;
    assign in_dec = ref_decode(in_op[5:3], in_op[2:0]);

    function automatic logic model_hazard();
        return m_valid && m_ctrl[4] && in_valid && (in_rs == m_rd);
    endfunction

    function automatic logic model_in_ready();
        return !m_halt && !m_stall && !flush && !model_hazard() && (!m_valid || out_ready);
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_valid <= 1'b0; m_ctrl <= 9'd0; m_rd <= 3'd0;
            m_stall <= 1'b0; m_halt <= 1'b0; m_ill <= 1'b0;
        end else if (m_halt) begin
            m_valid <= 1'b0;
        end else if (flush) begin
            m_valid <= 1'b0; m_stall <= 1'b0;
        end else if (m_stall) begin
            if (out_ready) begin m_valid <= 1'b0; m_stall <= 1'b0; end
        end else if (in_valid && model_in_ready()) begin
            if (in_dec[9]) begin
                m_halt <= 1'b1; m_ill <= 1'b1; m_valid <= 1'b0;
            end else begin
                m_valid <= 1'b1; m_ctrl <= in_dec[8:0]; m_rd <= in_rd;
            end
        end else begin
            if (out_ready) m_valid <= 1'b0;
            if (model_hazard()) m_stall <= 1'b1;
        end
    end

    task automatic drive(input logic v, input logic [5:0] op, input logic [2:0] rs,
                         input logic [2:0] rd, input logic ordy, input logic fl);
        in_valid = v; in_op = op; in_rs = rs; in_rd = rd; out_ready = ordy; flush = fl;
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        drive(1'b0, 6'd0, 3'd0, 3'd0, 1'b1, 1'b0);
        #1;
        checks += 6;
        if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        if (out_ctrl !== 9'd0) begin failures++; $display("FAIL reset_out_ctrl got=%b exp=0", out_ctrl); end
        if (out_rd !== 3'd0) begin failures++; $display("FAIL reset_out_rd got=%0d exp=0", out_rd); end
        if (illegal !== 1'b0) begin failures++; $display("FAIL reset_illegal got=%b exp=0", illegal); end
        if (halted !== 1'b0) begin failures++; $display("FAIL reset_halted got=%b exp=0", halted); end
        if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        cycle();
    endtask

    task automatic test_issue();
        drive(1'b1, 6'b100000, 3'd0, 3'd5, 1'b1, 1'b0);
        cycle();
        drive(1'b0, 6'd0, 3'd0, 3'd0, 1'b1, 1'b0);
        checks += 3;
        if (out_valid !== 1'b1) begin failures++; $display("FAIL issue_valid got=%b exp=1", out_valid); end
        if (out_ctrl !== 9'b100000010) begin failures++; $display("FAIL issue_ctrl got=%b exp=100000010", out_ctrl); end
        if (out_rd !== 3'd5) begin failures++; $display("FAIL issue_rd got=%0d exp=5", out_rd); end
        cycle();
    endtask

    task automatic test_back_to_back();
        drive(1'b1, 6'b000000, 3'd1, 3'd2, 1'b1, 1'b0);
        cycle();
        drive(1'b1, 6'b100000, 3'd4, 3'd6, 1'b1, 1'b0);
        #1;
        checks += 2;
        if (in_ready !== 1'b1) begin failures++; $display("FAIL b2b_in_ready got=%b exp=1", in_ready); end
        if (out_ctrl !== 9'b100000000) begin failures++; $display("FAIL b2b_first_ctrl got=%b exp=100000000", out_ctrl); end
        cycle();
        drive(1'b0, 6'd0, 3'd0, 3'd0, 1'b1, 1'b0);
        checks += 3;
        if (out_valid !== 1'b1) begin failures++; $display("FAIL b2b_valid got=%b exp=1", out_valid); end
        if (out_ctrl !== 9'b100000010) begin failures++; $display("FAIL b2b_second_ctrl got=%b exp=100000010", out_ctrl); end
        if (out_rd !== 3'd6) begin failures++; $display("FAIL b2b_rd got=%0d exp=6", out_rd); end
        cycle();
    endtask

    task automatic test_load_use();
        drive(1'b1, 6'b001000, 3'd0, 3'd3, 1'b1, 1'b0);
        cycle();
        checks += 1;
        if (out_ctrl !== 9'b100010000) begin failures++; $display("FAIL lu_lwr_ctrl got=%b exp=100010000", out_ctrl); end
        drive(1'b1, 6'b101000, 3'd3, 3'd1, 1'b1, 1'b0);
        #1;
        checks += 1;
        if (in_ready !== 1'b0) begin failures++; $display("FAIL lu_hazard_ready got=%b exp=0", in_ready); end
        cycle();
        checks += 2;
        if (out_valid !== 1'b0) begin failures++; $display("FAIL lu_bubble got=%b exp=0", out_valid); end
        if (in_ready !== 1'b0) begin failures++; $display("FAIL lu_stall_ready got=%b exp=0", in_ready); end
        cycle();
        checks += 1;
        if (in_ready !== 1'b1) begin failures++; $display("FAIL lu_resume_ready got=%b exp=1", in_ready); end
        cycle();
        drive(1'b0, 6'd0, 3'd0, 3'd0, 1'b1, 1'b0);
        checks += 3;
        if (out_valid !== 1'b1) begin failures++; $display("FAIL lu_gr_valid got=%b exp=1", out_valid); end
        if (out_ctrl !== 9'b100000001) begin failures++; $display("FAIL lu_gr_ctrl got=%b exp=100000001", out_ctrl); end
        if (out_rd !== 3'd1) begin failures++; $display("FAIL lu_gr_rd got=%0d exp=1", out_rd); end
        cycle();
    endtask

    task automatic test_backpressure();
        drive(1'b1, 6'b010000, 3'd0, 3'd7, 1'b1, 1'b0);
        cycle();
        drive(1'b1, 6'b100000, 3'd2, 3'd2, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            #1;
            checks += 4;
            if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_in_ready[%0d] got=%b exp=0", i, in_ready); end
            if (out_valid !== 1'b1) begin failures++; $display("FAIL bp_valid[%0d] got=%b exp=1", i, out_valid); end
            if (out_ctrl !== 9'b110000001) begin failures++; $display("FAIL bp_ctrl[%0d] got=%b exp=110000001", i, out_ctrl); end
            if (out_rd !== 3'd7) begin failures++; $display("FAIL bp_rd[%0d] got=%0d exp=7", i, out_rd); end
            cycle();
        end
        drive(1'b0, 6'd0, 3'd0, 3'd0, 1'b1, 1'b0);
        cycle();
        checks += 1;
        if (out_valid !== 1'b0) begin failures++; $display("FAIL bp_drain got=%b exp=0", out_valid); end
    endtask

    task automatic test_flush();
        drive(1'b1, 6'b100000, 3'd0, 3'd1, 1'b1, 1'b0);
        cycle();
        drive(1'b1, 6'b010101, 3'd0, 3'd2, 1'b0, 1'b1);
        #1;
        checks += 1;
        if (in_ready !== 1'b0) begin failures++; $display("FAIL flush_in_ready got=%b exp=0", in_ready); end
        cycle();
        drive(1'b0, 6'd0, 3'd0, 3'd0, 1'b1, 1'b0);
        checks += 1;
        if (out_valid !== 1'b0) begin failures++; $display("FAIL flush_valid got=%b exp=0", out_valid); end
        cycle();
        checks += 1;
        if (out_valid !== 1'b0) begin failures++; $display("FAIL flush_brc_issued got=%b exp=0", out_valid); end
    endtask

    task automatic test_illegal();
        drive(1'b1, 6'b001111, 3'd0, 3'd0, 1'b1, 1'b0);
        #1;
        checks += 1;
        if (in_ready !== 1'b1) begin failures++; $display("FAIL ill_accept_ready got=%b exp=1", in_ready); end
        cycle();
        drive(1'b1, 6'b000000, 3'd0, 3'd0, 1'b1, 1'b1);
        checks += 3;
        if (illegal !== 1'b1) begin failures++; $display("FAIL ill_flag got=%b exp=1", illegal); end
        if (halted !== 1'b1) begin failures++; $display("FAIL ill_halted got=%b exp=1", halted); end
        if (out_valid !== 1'b0) begin failures++; $display("FAIL ill_valid got=%b exp=0", out_valid); end
        for (int i = 0; i < 3; i++) begin
            if (i == 1) flush = 1'b0;
            #1;
            checks += 2;
            if (in_ready !== 1'b0) begin failures++; $display("FAIL ill_in_ready[%0d] got=%b exp=0", i, in_ready); end
            if (halted !== 1'b1) begin failures++; $display("FAIL ill_stay_halted[%0d] got=%b exp=1", i, halted); end
            cycle();
        end
        drive(1'b0, 6'd0, 3'd0, 3'd0, 1'b1, 1'b0);
        #1 reset = 1'b1;
        #1;
        checks += 2;
        if (illegal !== 1'b0) begin failures++; $display("FAIL ill_async_clear got=%b exp=0", illegal); end
        if (halted !== 1'b0) begin failures++; $display("FAIL halt_async_clear got=%b exp=0", halted); end
        #1 reset = 1'b0;
        cycle();
        checks += 1;
        if (in_ready !== 1'b1) begin failures++; $display("FAIL ill_post_reset_ready got=%b exp=1", in_ready); end
    endtask

    task automatic test_wide_op();
        logic [7:0] ops [4];
        logic [9:0] e;
        ops[0] = 8'b11100000; ops[1] = 8'b11111100; ops[2] = 8'b00111000; ops[3] = 8'b01011101;
        for (int i = 0; i < 4; i++) begin
            w_in_valid = 1'b1; w_in_op = ops[i]; w_in_rs = 3'd0; w_in_rd = 3'(i);
            w_flush = 1'b0; w_out_ready = 1'b1;
            e = ref_decode(ops[i][7:5], ops[i][2:0]);
            cycle();
            checks += 3;
            if (w_out_valid !== 1'b1) begin failures++; $display("FAIL wide_valid[%0d] got=%b exp=1", i, w_out_valid); end
            if (w_out_ctrl !== e[8:0]) begin failures++; $display("FAIL wide_ctrl[%0d] got=%b exp=%b", i, w_out_ctrl, e[8:0]); end
            if (w_illegal !== 1'b0) begin failures++; $display("FAIL wide_illegal[%0d] got=%b exp=0", i, w_illegal); end
            if (i == 0) begin
                checks += 1;
                if (w_out_ctrl !== 9'b000000111) begin failures++; $display("FAIL wide_j_ctrl got=%b exp=000000111", w_out_ctrl); end
            end
        end
        w_in_valid = 1'b0;
        cycle();
        checks += 2;
        if (w_out_valid !== 1'b0) begin failures++; $display("FAIL wide_drain got=%b exp=0", w_out_valid); end
        if (w_halted !== 1'b0) begin failures++; $display("FAIL wide_halted got=%b exp=0", w_halted); end
    endtask

    task automatic test_random();
        logic [5:0] op;
        for (int n = 0; n < 400; n++) begin
            op = 6'($urandom_range(0, 63));
            if (op[5:3] == 3'b001 && op[2:0] > 3'd2) op[2:0] = 3'($urandom_range(0, 2));
            drive(($urandom_range(0, 9) < 7), op, 3'($urandom_range(0, 3)), 3'($urandom_range(0, 3)),
                  ($urandom_range(0, 9) < 7), ($urandom_range(0, 19) == 0));
            #1;
            checks += 1;
            if (in_ready !== model_in_ready()) begin failures++; $display("FAIL rnd_in_ready[%0d] got=%b exp=%b", n, in_ready, model_in_ready()); end
            cycle();
            checks += 3;
            if (out_valid !== m_valid) begin failures++; $display("FAIL rnd_valid[%0d] got=%b exp=%b", n, out_valid, m_valid); end
            if (halted !== m_halt) begin failures++; $display("FAIL rnd_halted[%0d] got=%b exp=%b", n, halted, m_halt); end
            if (illegal !== m_ill) begin failures++; $display("FAIL rnd_illegal[%0d] got=%b exp=%b", n, illegal, m_ill); end
            if (m_valid) begin
                checks += 2;
                if (out_ctrl !== m_ctrl) begin failures++; $display("FAIL rnd_ctrl[%0d] got=%b exp=%b", n, out_ctrl, m_ctrl); end
                if (out_rd !== m_rd) begin failures++; $display("FAIL rnd_rd[%0d] got=%0d exp=%0d", n, out_rd, m_rd); end
            end
        end
        drive(1'b0, 6'd0, 3'd0, 3'd0, 1'b1, 1'b0);
        cycle();
    endtask

    initial begin
        drive(1'b0, 6'd0, 3'd0, 3'd0, 1'b1, 1'b0);
        w_in_valid = 1'b0; w_in_op = 8'd0; w_in_rs = 3'd0; w_in_rd = 3'd0;
        w_flush = 1'b0; w_out_ready = 1'b1;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #3 reset = 1'b0;
        cycle();
        test_reset();
        test_issue();
        test_back_to_back();
        test_load_use();
        test_backpressure();
        test_flush();
        test_illegal();
        test_wide_op();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
